// File: rtl/mmio_timer_if.sv
// Data-port bus between the core and the timer: address, store data/strobe in,
// select flag and zero-latency read data out.
interface mmio_timer_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        write_en;
    logic        sel;
    logic [31:0] read_data;

    modport master (output addr, output write_data, output write_en,
                    input  sel,  input  read_data);
    modport slave  (input  addr, input  write_data, input  write_en,
                    output sel,  output read_data);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare/auto-reload, overflow flag
// and level interrupt; decodes a 32-byte window on the core's data-memory bus.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus,
    output logic         irq
);

    localparam logic [2:0]  OFF_CTRL     = 3'd0;
    localparam logic [2:0]  OFF_PRESCALE = 3'd1;
    localparam logic [2:0]  OFF_COUNT    = 3'd2;
    localparam logic [2:0]  OFF_COMPARE  = 3'd3;
    localparam logic [2:0]  OFF_STATUS   = 3'd4;
    localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

    logic        en, reload, irq_en, match, ovf;
    logic [15:0] prescale, pcnt;
    logic [31:0] count, compare, rdata;
    logic        hit, wr, tick, cmp_eq, at_max, match_set, ovf_set;
    logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic [2:0]  off;

    assign hit         = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off         = bus.addr[4:2];
    assign wr          = bus.write_en & hit;
    assign wr_ctrl     = wr && (off == OFF_CTRL);
    assign wr_prescale = wr && (off == OFF_PRESCALE);
    assign wr_count    = wr && (off == OFF_COUNT);
    assign wr_compare  = wr && (off == OFF_COMPARE);
    assign wr_status   = wr && (off == OFF_STATUS);

    // A PRESCALE write restarts the prescaler and suppresses that cycle's tick.
    assign tick      = en && (pcnt == prescale) && !wr_prescale;
    assign cmp_eq    = (count == compare);
    assign at_max    = (count == ALL_ONES);
    assign match_set = tick & cmp_eq;
    assign ovf_set   = tick & at_max & ~(cmp_eq & reload);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en       <= 1'b0;
            reload   <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
            pcnt     <= '0;
            count    <= '0;
            compare  <= ALL_ONES;
            match    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (wr_ctrl)
                {irq_en, reload, en} <= bus.write_data[2:0];

            if (wr_prescale) begin
                prescale <= bus.write_data[15:0];
                pcnt     <= '0;
            end else if (en) begin
                pcnt <= (pcnt == prescale) ? 16'd0 : pcnt + 16'd1;
            end

            if (wr_compare)
                compare <= bus.write_data;

            // Software write beats the tick's increment; flags still see the old count.
            if (wr_count)
                count <= bus.write_data;
            else if (tick)
                count <= (cmp_eq && reload) ? 32'd0 : count + 32'd1;

            match <= match_set | (match & ~(wr_status & bus.write_data[0]));
            ovf   <= ovf_set   | (ovf   & ~(wr_status & bus.write_data[1]));
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:     rdata = {29'd0, irq_en, reload, en};
                OFF_PRESCALE: rdata = {16'd0, prescale};
                OFF_COUNT:    rdata = count;
                OFF_COMPARE:  rdata = compare;
                OFF_STATUS:   rdata = {30'd0, ovf, match};
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.sel       = hit;
    assign bus.read_data = rdata;
    assign irq           = irq_en & match;

endmodule
